// File: rtl/intr_responder.sv
// rtl/intr_responder.sv - sticky error-interrupt consumer: capture cause+timestamp, pulse clear, queue events
module intr_responder #(
  parameter int CAUSE_W = 2,
  parameter int DEPTH   = 4,
  parameter int TS_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic               irq_in,
  input  logic [CAUSE_W-1:0] cause_in,
  output logic               intr_clr_o,
  output logic               evt_valid_o,
  input  logic               evt_ready_i,
  output logic [CAUSE_W-1:0] evt_cause_o,
  output logic [TS_W-1:0]    evt_ts_o,
  output logic               overflow_o,
  output logic [7:0]         drop_cnt_o,
  input  logic               ovf_clr_i,
  output logic               busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CAUSE_W + TS_W;

  typedef enum logic [1:0] {IDLE, CLEAR, SETTLE} state_t;

  state_t          state;
  logic [TS_W-1:0] ts;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;

  logic            capture;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            drop;
  logic [AW:0]     wptr_nxt;
  logic [AW:0]     rptr_nxt;
  logic [EW-1:0]   head_nxt;

  assign capture     = (state == IDLE) && enable_i && irq_in;
  assign evt_valid_o = (wptr != rptr);
  assign full        = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop         = evt_valid_o && evt_ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok     = capture && (!full || pop);
  assign drop        = capture && !push_ok;
  assign wptr_nxt    = wptr + {{AW{1'b0}}, push_ok};
  assign rptr_nxt    = rptr + {{AW{1'b0}}, pop};

  // Head register: bypass the incoming entry when it becomes the head, hold when empty.
  always_comb begin
    head_nxt = {evt_cause_o, evt_ts_o};
    if (wptr_nxt != rptr_nxt) begin
      if (push_ok && (rptr_nxt == wptr)) begin
        head_nxt = {cause_in, ts};
      end else begin
        head_nxt = mem[rptr_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[AW-1:0]] <= {cause_in, ts};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      intr_clr_o  <= 1'b0;
      busy_o      <= 1'b0;
      ts          <= '0;
      wptr        <= '0;
      rptr        <= '0;
      evt_cause_o <= '0;
      evt_ts_o    <= '0;
      overflow_o  <= 1'b0;
      drop_cnt_o  <= 8'd0;
    end else begin
      ts <= ts + TS_W'(1);

      case (state)
        IDLE: begin
          if (capture) begin
            state      <= CLEAR;
            intr_clr_o <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        CLEAR: begin
          state      <= SETTLE;
          intr_clr_o <= 1'b0;
        end
        SETTLE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          intr_clr_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase

      wptr                    <= wptr_nxt;
      rptr                    <= rptr_nxt;
      {evt_cause_o, evt_ts_o} <= head_nxt;

      // A drop coinciding with a clear request restarts the count at one.
      if (drop) begin
        overflow_o <= 1'b1;
        if (ovf_clr_i) begin
          drop_cnt_o <= 8'd1;
        end else if (drop_cnt_o != 8'hFF) begin
          drop_cnt_o <= drop_cnt_o + 8'd1;
        end
      end else if (ovf_clr_i) begin
        overflow_o <= 1'b0;
        drop_cnt_o <= 8'd0;
      end
    end
  end

endmodule
